// File: rtl/regfile_dump.sv
// regfile_dump: debug read-out engine for the integer register file.
// Walks a requested index range on a spare read port and streams each
// captured value out over a valid/ready interface, ending with a done pulse.
module regfile_dump #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W-1:0] last_reg,
  output logic [ADDR_W-1:0] rf_readRegister,
  input  logic [DATA_W-1:0] rf_readData,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [DATA_W-1:0] dump_data,
  output logic [ADDR_W-1:0] dump_index,
  output logic              dump_last,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLoad = 2'd1;
  localparam logic [1:0] StSend = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  localparam logic [ADDR_W-1:0] AddrOne = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [1:0]        stateQ, stateD;
  logic [ADDR_W-1:0] addrQ, addrD;
  logic [ADDR_W-1:0] endQ, endD;
  logic [DATA_W-1:0] dataQ, dataD;
  logic [ADDR_W-1:0] indexQ, indexD;
  logic              lastQ, lastD;
  logic              validQ, validD;
  logic              errorQ, errorD;

  // Next-state logic for the dump sequencer and its output holding registers.
  always_comb begin
    stateD = stateQ;
    addrD  = addrQ;
    endD   = endQ;
    dataD  = dataQ;
    indexD = indexQ;
    lastD  = lastQ;
    validD = validQ;
    errorD = 1'b0;
    case (stateQ)
      StIdle: begin
        if (start) begin
          if (first_reg <= last_reg) begin
            endD   = last_reg;
            addrD  = first_reg;
            stateD = StLoad;
          end else begin
            errorD = 1'b1;
          end
        end
      end
      StLoad: begin
        dataD  = rf_readData;
        indexD = addrQ;
        lastD  = (addrQ == endQ);
        validD = 1'b1;
        stateD = StSend;
      end
      StSend: begin
        if (dump_ready) begin
          validD = 1'b0;
          if (lastQ) begin
            stateD = StDone;
          end else begin
            // Cannot wrap: the last word of a run never reaches this branch.
            addrD  = addrQ + AddrOne;
            stateD = StLoad;
          end
        end
      end
      StDone: begin
        stateD = StIdle;
      end
      default: begin
        stateD = StIdle;
      end
    endcase
  end

  // State and output registers, cleared immediately by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateQ <= StIdle;
      addrQ  <= '0;
      endQ   <= '0;
      dataQ  <= '0;
      indexQ <= '0;
      lastQ  <= 1'b0;
      validQ <= 1'b0;
      errorQ <= 1'b0;
    end else begin
      stateQ <= stateD;
      addrQ  <= addrD;
      endQ   <= endD;
      dataQ  <= dataD;
      indexQ <= indexD;
      lastQ  <= lastD;
      validQ <= validD;
      errorQ <= errorD;
    end
  end

  assign rf_readRegister = addrQ;
  assign dump_valid      = validQ;
  assign dump_data       = dataQ;
  assign dump_index      = indexQ;
  assign dump_last       = lastQ;
  assign busy            = (stateQ != StIdle);
  assign done            = (stateQ == StDone);
  assign error           = errorQ;

endmodule

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump: directed bench for regfile_dump with a behavioural
// register file and an expected-word scoreboard.
module tb_regfile_dump;

  logic        clk;
  logic        reset;
  logic        start;
  logic [4:0]  first_reg;
  logic [4:0]  last_reg;
  logic [4:0]  rf_readRegister;
  logic [63:0] rf_readData;
  logic        dump_valid;
  logic        dump_ready;
  logic [63:0] dump_data;
  logic [4:0]  dump_index;
  logic        dump_last;
  logic        busy;
  logic        done;
  logic        error;

  typedef struct packed {
    logic [4:0]  idx;
    logic [63:0] data;
    logic        last;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] rf[32];
  int          total = 0;
  int          bad   = 0;

  regfile_dump #(.DATA_W(64), .ADDR_W(5)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .first_reg      (first_reg),
    .last_reg       (last_reg),
    .rf_readRegister(rf_readRegister),
    .rf_readData    (rf_readData),
    .dump_valid     (dump_valid),
    .dump_ready     (dump_ready),
    .dump_data      (dump_data),
    .dump_index     (dump_index),
    .dump_last      (dump_last),
    .busy           (busy),
    .done           (done),
    .error          (error)
  );

  assign rf_readData = rf[rf_readRegister];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rdreg"}, 64'(rf_readRegister), 64'd0);
    chk({tag, "_valid"}, 64'(dump_valid), 64'd0);
    chk({tag, "_data"},  dump_data, 64'd0);
    chk({tag, "_index"}, 64'(dump_index), 64'd0);
    chk({tag, "_last"},  64'(dump_last), 64'd0);
    chk({tag, "_busy"},  64'(busy), 64'd0);
    chk({tag, "_done"},  64'(done), 64'd0);
    chk({tag, "_error"}, 64'(error), 64'd0);
  endtask

  // Called at a negedge. mode 0: ready always high; mode 1: ready 0,0,1 per word.
  // inject: pulse a second start (20..21) while the run is in progress.
  task automatic run(input logic [4:0] f, input logic [4:0] l, input int mode,
                     input int exp_done, input bit inject);
    int  wait_cnt = 0;
    bit  got_done = 0;
    int  accepted = 0;
    int  expected_words;
    for (int i = int'(f); i <= int'(l); i++) begin
      sb.push_back('{idx: 5'(i), data: rf[i], last: (i == int'(l))});
    end
    expected_words = sb.size();
    first_reg  = f;
    last_reg   = l;
    start      = 1'b1;
    dump_ready = 1'b1;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (inject && cyc == 3) begin
        first_reg = 5'd20;
        last_reg  = 5'd21;
        start     = 1'b1;
      end
      chk("busy_in_run", 64'(busy), 64'd1);
      if (done) begin
        chk("done_cycle", 64'(cyc), 64'(exp_done));
        got_done = 1;
        break;
      end
      if (dump_valid) begin
        if (sb.size() == 0) begin
          chk("extra_word", 64'(dump_index), 64'hffff);
          dump_ready = 1'b1;
        end else begin
          chk("word_index", 64'(dump_index), 64'(sb[0].idx));
          chk("word_data",  dump_data, sb[0].data);
          chk("word_last",  64'(dump_last), 64'(sb[0].last));
          if (mode == 1 && wait_cnt < 2) begin
            dump_ready = 1'b0;
            wait_cnt++;
          end else begin
            dump_ready = 1'b1;
            wait_cnt   = 0;
            void'(sb.pop_front());
            accepted++;
          end
        end
      end
    end
    chk("done_seen", 64'(got_done), 64'd1);
    chk("words_accepted", 64'(accepted), 64'(expected_words));
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    sb.delete();
    dump_ready = 1'b1;
    @(negedge clk);
    chk("busy_after", 64'(busy), 64'd0);
    chk("done_after", 64'(done), 64'd0);
    chk("valid_after", 64'(dump_valid), 64'd0);
  endtask

  initial begin
    bit found;
    reset      = 1'b1;
    start      = 1'b0;
    first_reg  = '0;
    last_reg   = '0;
    dump_ready = 1'b1;
    for (int i = 0; i < 32; i++) rf[i] = 64'(i) * 64'h0101010101010101;

    // Reset state.
    #2;
    check_reset_outputs("rst");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("idle");

    // Full dump with no backpressure: 32 words, done 65 cycles after start.
    run(5'd0, 5'd31, 0, 65, 1'b0);

    // Backpressure over 3..5.
    run(5'd3, 5'd5, 1, 13, 1'b0);

    // Single register.
    run(5'd17, 5'd17, 0, 3, 1'b0);

    // Rejected range: one-cycle error, nothing else.
    first_reg = 5'd7;
    last_reg  = 5'd3;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rej_error", 64'(error), 64'd1);
    chk("rej_busy", 64'(busy), 64'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rej_error_clear", 64'(error), 64'd0);
      chk("rej_busy_low", 64'(busy), 64'd0);
      chk("rej_no_valid", 64'(dump_valid), 64'd0);
      chk("rej_no_done", 64'(done), 64'd0);
    end

    // Reset mid-run while SEND holds index 10.
    first_reg = 5'd8;
    last_reg  = 5'd15;
    start     = 1'b1;
    found     = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (dump_valid && dump_index == 5'd10) begin
        dump_ready = 1'b0;
        found      = 1;
        break;
      end
      dump_ready = 1'b1;
    end
    chk("midrun_reached_10", 64'(found), 64'd1);
    @(negedge clk);
    chk("midrun_held_valid", 64'(dump_valid), 64'd1);
    chk("midrun_held_index", 64'(dump_index), 64'd10);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("midrun_rst");
    @(negedge clk);
    reset      = 1'b0;
    dump_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("midrun_no_done", 64'(done), 64'd0);
      chk("midrun_no_valid", 64'(dump_valid), 64'd0);
    end
    run(5'd0, 5'd1, 0, 5, 1'b0);

    // Start while busy is ignored.
    run(5'd0, 5'd2, 0, 7, 1'b1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("ignored_start_idle", 64'(busy), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
